// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and default geometry for the main-memory arbiter.
//   state_e    : arbiter FSM states (IDLE, BURST, RESP)
//   gnt_e      : which cache owns the memory port (GNT_I, GNT_D)
//   BEAT_W     : beat index width for the default line size
//   LINE_OFF_W : byte-offset bits inside a default line (BEAT_W + 2)
package mem_arb_pkg;

  localparam int unsigned LINE_WORDS_DFLT = 4;
  localparam int unsigned BEAT_W          = $clog2(LINE_WORDS_DFLT);
  localparam int unsigned LINE_OFF_W      = BEAT_W + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_beat_ctr.sv
// mem_arb_beat_ctr: beat counter for one cache-line burst.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : advance by one (wraps naturally at 2**W)
//   cnt_o  : current beat index
//   last_o : current beat is the final beat of the line
module mem_arb_beat_ctr #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  // Line length is a power of two, so the last beat is the all-ones index.
  assign last_o = &cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported main memory between I-cache refills
// and D-cache refills/writebacks. Each grant runs a LINE_WORDS-beat burst.
//   clk, reset                  : clock, synchronous active-high reset
//   i_req/i_addr                : I-cache line fill request
//   i_rdata/i_rvalid/i_done     : I-cache fill data and completion pulse
//   d_req/d_we/d_addr/d_wdata   : D-cache fill (d_we=0) or writeback (d_we=1)
//   d_widx                      : beat index, lets the D-cache drive d_wdata
//   d_rdata/d_rvalid/d_done     : D-cache fill data and completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : memory beat port
// Build option MEM_ARB_RR_EN: round-robin on simultaneous requests instead of
// fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W     = 32,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned LINE_WORDS = LINE_WORDS_DFLT,
  localparam int unsigned BW         = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [BW-1:0]     d_widx,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned OFF_W = BW + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

  state_e            st_q, st_d;
  gnt_e              grant_q, grant_d, sel;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [BW-1:0]     beat;
  logic              beat_last;
  logic              start, in_burst, rd_beat;

  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              i_rvalid_q, d_rvalid_q;

  assign start    = (st_q == S_IDLE) && (i_req || d_req);
  assign in_burst = (st_q == S_BURST);
  assign rd_beat  = in_burst && mem_ack && !we_q;

  // Cleared every IDLE cycle so each burst starts at beat 0; the ack on the
  // last beat wraps it back to 0 on the way into RESP.
  mem_arb_beat_ctr #(.W(BW)) u_beat (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (st_q == S_IDLE),
    .en_i   (in_burst && mem_ack),
    .cnt_o  (beat),
    .last_o (beat_last)
  );

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) st_q <= S_IDLE;
    else       st_q <= st_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE:  if (i_req || d_req)       st_d = S_BURST;
      S_BURST: if (mem_ack && beat_last) st_d = S_RESP;
      S_RESP:                            st_d = S_IDLE;
      default:                           st_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    mem_req  = in_burst;
    mem_we   = in_burst && (grant_q == GNT_D) && we_q;
    mem_addr = in_burst ? (base_q + (ADDR_W'(beat) << 2)) : '0;
    i_done   = (st_q == S_RESP) && (grant_q == GNT_I);
    d_done   = (st_q == S_RESP) && (grant_q == GNT_D);
  end

  // ---- grant / burst context captured in IDLE ----
  always_comb begin
    sel     = d_req ? GNT_D : GNT_I;
`ifdef MEM_ARB_RR_EN
    // grant_q doubles as the last-grant record: it changes on every grant.
    if (i_req && d_req && (grant_q == GNT_D)) sel = GNT_I;
`endif
    grant_d = grant_q;
    base_d  = base_q;
    we_d    = we_q;
    if (start) begin
      grant_d = sel;
      base_d  = ((sel == GNT_D) ? d_addr : i_addr) & LINE_MASK;
      we_d    = (sel == GNT_D) && d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= GNT_I;
      base_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      grant_q <= grant_d;
      base_q  <= base_d;
      we_q    <= we_d;
    end
  end

  // ---- read return: one cycle after each read ack ----
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      i_rvalid_q <= rd_beat && (grant_q == GNT_I);
      d_rvalid_q <= rd_beat && (grant_q == GNT_D);
      if (rd_beat && (grant_q == GNT_I)) i_rdata_q <= mem_rdata;
      if (rd_beat && (grant_q == GNT_D)) d_rdata_q <= mem_rdata;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_rvalid  = i_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_widx    = beat;
  assign mem_wdata = d_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected beats, fill
// words and done pulses of each burst; a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  d_widx;
  logic        i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_widx(d_widx),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int total = 0, bad = 0;

  typedef struct { bit isd; bit we; logic [31:0] addr; int idx; } beat_t;
  typedef struct { bit isd; bit we; } done_t;
  beat_t       beat_q[$];
  logic [31:0] ird_q[$], drd_q[$];
  done_t       done_q[$];
  bit          last_d = 1'b0;   // model of last grant: 0 = I, 1 = D
  logic [31:0] wsalt = 32'h1234_0000;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] wfn(input logic [31:0] s, input int idx);
    return s ^ (32'(idx) * 32'h0101_0101 + 32'h77);
  endfunction

  // D-cache side: write data follows the beat index the arbiter presents.
  assign d_wdata = wfn(wsalt, int'(d_widx));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexp(input string nm);
    total++; bad++;
    $display("FAIL %s: output seen with nothing expected (t=%0t)", nm, $time);
  endtask

  // Expected behaviour of one granted burst, straight from the line rules.
  task automatic push_exp(input bit isd, input bit we, input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'h0000_000F;
    for (int k = 0; k < 4; k++) begin
      beat_q.push_back('{isd, we, base + 32'(4 * k), k});
      if (!we) begin
        if (isd) drd_q.push_back(mem_fn(base + 32'(4 * k)));
        else     ird_q.push_back(mem_fn(base + 32'(4 * k)));
      end
    end
    done_q.push_back('{isd, we});
    last_d = isd;
  endtask

  // ---------------- memory model ----------------
  int ack_mode = 0;      // 0 always, 1 alternate, 2 random
  int stall_len = 0, stall_tag = 0;
  int m_seen_tag = 0, m_scnt = 0;
  bit m_alt = 1'b0;

  always @(posedge clk) begin
    #1;
    if (stall_tag != m_seen_tag) begin
      m_seen_tag = stall_tag;
      m_scnt = stall_len;
    end
    if (mem_req) begin
      if (m_scnt > 0) begin
        mem_ack = 1'b0;
        m_scnt--;
      end else begin
        case (ack_mode)
          0:       mem_ack = 1'b1;
          1:       begin m_alt = ~m_alt; mem_ack = m_alt; end
          default: mem_ack = 1'($urandom_range(0, 1));
        endcase
      end
    end else begin
      mem_ack = 1'b0;
    end
    mem_rdata = mem_fn(mem_addr);
  end

  // ---------------- monitor ----------------
  beat_t       mb;
  done_t       md;
  bit          hold_prev = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic done_pop(input bit who);
    if (done_q.size() == 0) unexp(who ? "d_done" : "i_done");
    else begin
      md = done_q.pop_front();
      chk("done_owner", 32'(who), 32'(md.isd));
      if (!md.we) chk("rvalid_with_done", 32'(who ? d_rvalid : i_rvalid), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_hold_req", 32'(mem_req), 32'd1);
        chk("stall_hold_addr", mem_addr, prev_addr);
      end
      hold_prev = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (mem_req && mem_ack) begin
        if (beat_q.size() == 0) unexp("mem_beat");
        else begin
          mb = beat_q.pop_front();
          chk("mem_addr", mem_addr, mb.addr);
          chk("mem_we", 32'(mem_we), 32'(mb.we));
          if (mb.isd) chk("d_widx", 32'(d_widx), 32'(mb.idx));
          if (mb.we)  chk("mem_wdata", mem_wdata, wfn(wsalt, mb.idx));
        end
      end
      if (i_rvalid) begin
        if (ird_q.size() == 0) unexp("i_rvalid");
        else chk("i_rdata", i_rdata, ird_q.pop_front());
      end
      if (d_rvalid) begin
        if (drd_q.size() == 0) unexp("d_rvalid");
        else chk("d_rdata", d_rdata, drd_q.pop_front());
      end
      if (i_done) done_pop(1'b0);
      if (d_done) done_pop(1'b1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // One requester; exp_lat > 0 checks cycles from request to done.
  task automatic run_burst(input bit isd, input bit we, input logic [31:0] a,
                           input int exp_lat, input int drop_at);
    int n = 0;
    bit seen = 1'b0;
    push_exp(isd, we, a);
    if (isd) begin d_req = 1'b1; d_we = we; d_addr = a; end
    else     begin i_req = 1'b1; i_addr = a; end
    while (n < 200 && !seen) begin
      @(posedge clk); #1; n++;
      if (n == drop_at) begin i_req = 1'b0; d_req = 1'b0; end
      seen = isd ? d_done : i_done;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("burst_completed", 32'(seen), 32'd1);
    if (seen && exp_lat > 0) chk("burst_latency", 32'(n), 32'(exp_lat));
    idle_cycle();
  endtask

  // Both requesters rise together; second burst must start two cycles after
  // the first done (one IDLE cycle in between).
  task automatic run_tie(input bit dwe, input logic [31:0] ia, input logic [31:0] da);
    bit dfirst;
    int n = 0, since = -1, gap = -1;
    bit idn = 1'b0, ddn = 1'b0;
`ifdef MEM_ARB_RR_EN
    dfirst = !last_d;
`else
    dfirst = 1'b1;
`endif
    if (dfirst) begin push_exp(1'b1, dwe, da); push_exp(1'b0, 1'b0, ia); end
    else        begin push_exp(1'b0, 1'b0, ia); push_exp(1'b1, dwe, da); end
    i_req = 1'b1; i_addr = ia;
    d_req = 1'b1; d_we = dwe; d_addr = da;
    while (n < 400 && !(idn && ddn)) begin
      @(posedge clk); #1; n++;
      if (since >= 0) since++;
      if (since > 0 && gap < 0 && mem_req) gap = since;
      if ((i_done || d_done) && since < 0) since = 0;
      if (i_done) begin idn = 1'b1; i_req = 1'b0; end
      if (d_done) begin ddn = 1'b1; d_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("tie_both_done", 32'(idn && ddn), 32'd1);
    chk("tie_gap", 32'(gap), 32'd2);
    idle_cycle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_i_done", 32'(i_done), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    chk("rst_d_widx", 32'(d_widx), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    idle_cycle();

    // I fill, ack every cycle: done LINE_WORDS+1 cycles after the request.
    ack_mode = 0;
    run_burst(1'b0, 1'b0, 32'h0040_001C, 5, 0);

    // D writeback with acks on alternate cycles.
    ack_mode = 1; wsalt = 32'hCAFE_0000;
    run_burst(1'b1, 1'b1, 32'h1000_0008, 0, 0);

    // D fill, ack every cycle.
    ack_mode = 0;
    run_burst(1'b1, 1'b0, 32'h2000_0034, 5, 0);

    // Two simultaneous ties.
    run_tie(1'b0, 32'h0000_1100, 32'h0000_2200);
    wsalt = 32'hBEEF_0000;
    run_tie(1'b1, 32'h0000_1140, 32'h0000_2280);

    // Reset while beat 3 is outstanding: no done, fresh burst from beat 0.
    push_exp(1'b0, 1'b0, 32'h0000_2004);
    i_req = 1'b1; i_addr = 32'h0000_2004;
    repeat (4) idle_cycle();
    reset = 1'b1; i_req = 1'b0;
    idle_cycle();
    chk("abort_mem_req", 32'(mem_req), 32'd0);
    chk("abort_i_done", 32'(i_done), 32'd0);
    chk("abort_i_rvalid", 32'(i_rvalid), 32'd0);
    beat_q.delete(); ird_q.delete(); drd_q.delete(); done_q.delete();
    last_d = 1'b0;
    reset = 1'b0;
    idle_cycle();
    run_burst(1'b0, 1'b0, 32'h0000_3038, 5, 0);

    // Request dropped mid-burst: burst still completes.
    run_burst(1'b0, 1'b0, 32'h0000_4010, 5, 3);

    // Five-cycle stall on beat 0.
    stall_len = 5; stall_tag++;
    run_burst(1'b0, 1'b0, 32'h0000_5000, 10, 0);

    // Random traffic with random acks.
    ack_mode = 2;
    for (int it = 0; it < 40; it++) begin
      int kind;
      logic [31:0] a1, a2;
      kind = $urandom_range(0, 3);
      a1 = $urandom; a2 = $urandom;
      wsalt = $urandom;
      case (kind)
        0:       run_burst(1'b0, 1'b0, a1, 0, 0);
        1:       run_burst(1'b1, 1'b0, a1, 0, 0);
        2:       run_burst(1'b1, 1'b1, a1, 0, 0);
        default: run_tie(1'($urandom_range(0, 1)), a1, a2);
      endcase
    end

    repeat (3) idle_cycle();
    chk("left_beats", 32'(beat_q.size()), 32'd0);
    chk("left_i_rdata", 32'(ird_q.size()), 32'd0);
    chk("left_d_rdata", 32'(drd_q.size()), 32'd0);
    chk("left_done", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
